// File: rtl/fpu_add_core_if.sv
// rtl/fpu_add_core_if.sv - operand/command/result interface of the FPU add core
interface fpu_add_core_if;
  logic        start;
  logic [1:0]  command;
  logic [31:0] first;
  logic [31:0] second;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  modport master (
    output start, command, first, second,
    input  busy, done, result, overflow, invalid
  );

  modport slave (
    input  start, command, first, second,
    output busy, done, result, overflow, invalid
  );
endinterface

// File: rtl/fpu_add_core.sv
// rtl/fpu_add_core.sv - multi-cycle single-precision add/sub core; FPU_ADD_ROUND_NEAREST_EN selects RNE over truncation
module fpu_add_core #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clock,
  input  logic          reset,
  fpu_add_core_if.slave bus
);
  localparam int MW = MAN_W + 4;   // hidden 1 + stored mantissa + guard/round/sticky
  localparam int XW = EXP_W + 2;   // exponent headroom for carry and rounding increments
  localparam logic [XW-1:0] EXP_MAX = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic              sub_q, sub_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XW-1:0]     ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic              sign_q, sign_d;
  logic [XW-1:0]     exp_q, exp_d;
  logic [MW:0]       sum_q, sum_d;     // bit MW is the addition carry-out
  logic              spec_q, spec_d, nan_q, nan_d;
  logic              done_q, done_d, ovf_q, ovf_d, inv_q, inv_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [EXP_W-1:0]  a_exp, b_exp;
  logic              a_inf, b_inf, a_nan, b_nan;
  logic              swap, inc;
  logic [MW-1:0]     big_m, small_m;
  logic [XW-1:0]     big_e, diff;
  logic [4:0]        sh;
  logic [2*MW-1:0]   ext;
  logic [MAN_W+1:0]  rnd;

  assign a_exp = opa_q[WIDTH-2 -: EXP_W];
  assign b_exp = opb_q[WIDTH-2 -: EXP_W];

  assign bus.busy     = (state_q != S_IDLE) || done_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;

  // Next-state and datapath for every FSM step
  always_comb begin
    state_d = state_q; opa_d = opa_q; opb_d = opb_q; sub_d = sub_q;
    sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q; ma_d = ma_q; mb_d = mb_q;
    sign_d = sign_q; exp_d = exp_q; sum_d = sum_q; spec_d = spec_q; nan_d = nan_q;
    done_d = 1'b0; ovf_d = ovf_q; inv_d = inv_q; result_d = result_q;
    a_inf = 1'b0; b_inf = 1'b0; a_nan = 1'b0; b_nan = 1'b0;
    swap = 1'b0; inc = 1'b0; big_m = '0; small_m = '0; big_e = '0; diff = '0;
    sh = '0; ext = '0; rnd = '0;
    case (state_q)
      S_IDLE: begin
        // done_q still high means this is the done cycle: no accept yet
        if (bus.start && !done_q) begin
          opa_d   = bus.first;
          opb_d   = bus.second;
          sub_d   = (bus.command == 2'b01);
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sa_d   = opa_q[WIDTH-1];
        sb_d   = opb_q[WIDTH-1] ^ sub_q;
        ea_d   = {{(XW-EXP_W){1'b0}}, a_exp};
        eb_d   = {{(XW-EXP_W){1'b0}}, b_exp};
        ma_d   = (a_exp == '0) ? '0 : {1'b1, opa_q[MAN_W-1:0], 3'b000};
        mb_d   = (b_exp == '0) ? '0 : {1'b1, opb_q[MAN_W-1:0], 3'b000};
        spec_d = 1'b0;
        nan_d  = 1'b0;
        if (a_exp == '0 || b_exp == '0 || a_exp == '1 || b_exp == '1) state_d = S_SPECIAL;
        else state_d = S_ALIGN;
      end
      S_SPECIAL: begin
        a_nan  = (ea_q == EXP_MAX) && (ma_q[MW-2:3] != '0);
        b_nan  = (eb_q == EXP_MAX) && (mb_q[MW-2:3] != '0);
        a_inf  = (ea_q == EXP_MAX) && (ma_q[MW-2:3] == '0);
        b_inf  = (eb_q == EXP_MAX) && (mb_q[MW-2:3] == '0);
        spec_d = 1'b1;
        sum_d  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa_q != sb_q))) begin
          sign_d = 1'b0; exp_d = EXP_MAX; sum_d[MW-2] = 1'b1; nan_d = 1'b1;
        end else if (a_inf) begin
          sign_d = sa_q; exp_d = EXP_MAX;
        end else if (b_inf) begin
          sign_d = sb_q; exp_d = EXP_MAX;
        end else if (ea_q == '0 && eb_q == '0) begin
          sign_d = sa_q & sb_q; exp_d = '0;   // (+0)+(-0) gives +0
        end else if (ea_q == '0) begin
          sign_d = sb_q; exp_d = eb_q; sum_d = {1'b0, mb_q};
        end else begin
          sign_d = sa_q; exp_d = ea_q; sum_d = {1'b0, ma_q};
        end
        state_d = S_PACK;
      end
      S_ALIGN: begin
        swap    = (eb_q > ea_q);
        big_m   = swap ? mb_q : ma_q;
        small_m = swap ? ma_q : mb_q;
        big_e   = swap ? eb_q : ea_q;
        diff    = swap ? (eb_q - ea_q) : (ea_q - eb_q);
        sh      = (diff > XW'(MW)) ? 5'(MW) : diff[4:0];
        ext     = {small_m, {MW{1'b0}}} >> sh;
        ma_d    = big_m;
        mb_d    = ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |ext[MW-1:0]};
        sa_d    = swap ? sb_q : sa_q;
        sb_d    = swap ? sa_q : sb_q;
        exp_d   = big_e;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sa_q == sb_q) begin
          sum_d = {1'b0, ma_q} + {1'b0, mb_q}; sign_d = sa_q;
        end else if (ma_q >= mb_q) begin
          sum_d = {1'b0, ma_q - mb_q}; sign_d = sa_q;
        end else begin
          sum_d = {1'b0, mb_q - ma_q}; sign_d = sb_q;
        end
        if (sum_d == '0) begin
          sign_d = 1'b0; exp_d = '0; state_d = S_PACK;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (sum_q[MW]) begin
          sum_d   = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + XW'(1);
          state_d = S_ROUND;
        end else if (sum_q[MW-1]) begin
          state_d = S_ROUND;
        end else if (exp_q <= XW'(1)) begin
          sum_d = '0; exp_d = '0; state_d = S_ROUND;   // would go subnormal: flush
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - XW'(1);
          // leave as soon as the shift lands the leading 1 on the hidden bit
          if (sum_q[MW-2]) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
`ifdef FPU_ADD_ROUND_NEAREST_EN
        inc = sum_q[2] && (sum_q[1] || sum_q[0] || sum_q[3]);
`else
        inc = 1'b0;
`endif
        rnd = {1'b0, sum_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        if (rnd[MAN_W+1]) begin
          sum_d = {1'b0, rnd[MAN_W+1:1], 3'b000};
          exp_d = exp_q + XW'(1);
        end else begin
          sum_d = {1'b0, rnd[MAN_W:0], 3'b000};
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        inv_d = nan_q;
        ovf_d = 1'b0;
        if (!spec_q && exp_q >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[EXP_W-1:0], sum_q[MW-2:3]};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE; opa_q <= '0; opb_q <= '0; sub_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      sign_q <= 1'b0; exp_q <= '0; sum_q <= '0; spec_q <= 1'b0; nan_q <= 1'b0;
      done_q <= 1'b0; ovf_q <= 1'b0; inv_q <= 1'b0; result_q <= '0;
    end else begin
      state_q <= state_d; opa_q <= opa_d; opb_q <= opb_d; sub_q <= sub_d;
      sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d; ma_q <= ma_d; mb_q <= mb_d;
      sign_q <= sign_d; exp_q <= exp_d; sum_q <= sum_d; spec_q <= spec_d; nan_q <= nan_d;
      done_q <= done_d; ovf_q <= ovf_d; inv_q <= inv_d; result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_fpu_add_core.sv
// tb/tb_fpu_add_core.sv - directed self-checking bench for fpu_add_core
module tb_fpu_add_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   lat;
  logic ok;
  logic [31:0] rnd_exp;

  fpu_add_core_if bus_if ();

  fpu_add_core dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cmd);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_if.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus_if.start   = 1'b1;
    bus_if.first   = a;
    bus_if.second  = b;
    bus_if.command = cmd;
    @(posedge clk);
    #1;
    bus_if.start   = 1'b0;
    bus_if.first   = 32'hDEADBEEF;
    bus_if.second  = 32'h12345678;
    bus_if.command = 2'b01;
  endtask

  task automatic wait_done(input int poke, output int l, output logic got);
    l = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      l++;
      if (bus_if.done) begin
        got = 1'b1;
      end else if (l == poke) begin
        bus_if.start   = 1'b1;
        bus_if.first   = 32'h40000000;
        bus_if.second  = 32'h40000000;
        bus_if.command = 2'b00;
      end else if (l == poke + 1) begin
        bus_if.start = 1'b0;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] cmd, input logic [31:0] exp_res, input int exp_lat,
                          input logic exp_ovf, input logic exp_inv);
    int   l;
    logic got;
    launch(a, b, cmd);
    wait_done(-1, l, got);
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    chk({tag, "_res"}, bus_if.result, exp_res);
    chk({tag, "_ovf"}, 32'(bus_if.overflow), 32'(exp_ovf));
    chk({tag, "_inv"}, 32'(bus_if.invalid), 32'(exp_inv));
  endtask

  initial begin
    bus_if.start   = 1'b0;
    bus_if.command = 2'b00;
    bus_if.first   = 32'h0;
    bus_if.second  = 32'h0;
`ifdef FPU_ADD_ROUND_NEAREST_EN
    rnd_exp = 32'h3F800001;
`else
    rnd_exp = 32'h3F800000;
`endif

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_result", bus_if.result, 32'h0);
    chk("rst_ovf", 32'(bus_if.overflow), 32'd0);
    chk("rst_inv", 32'(bus_if.invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("neg_add", 32'hBF3FFFFF, 32'hBF3FFFFF, 2'b00, 32'hBFBFFFFF, 6, 1'b0, 1'b0);
    chk("done_busy", 32'(bus_if.busy), 32'd1);

    bus_if.start   = 1'b1;
    bus_if.first   = 32'h3F800000;
    bus_if.second  = 32'h3F800000;
    bus_if.command = 2'b00;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    chk("b2b_busy", 32'(bus_if.busy), 32'd0);
    chk("b2b_done", 32'(bus_if.done), 32'd0);
    chk("b2b_hold", bus_if.result, 32'hBFBFFFFF);

    op_check("sub_eq", 32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 4, 1'b0, 1'b0);
    op_check("inf_minf", 32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 3, 1'b0, 1'b1);
    op_check("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 6, 1'b1, 1'b0);
    op_check("round", 32'h3F800000, 32'h33C00000, 2'b00, rnd_exp, 6, 1'b0, 1'b0);
    op_check("two_m_one", 32'h40000000, 32'h3F800000, 2'b01, 32'h3F800000, 6, 1'b0, 1'b0);
    op_check("zero_sub", 32'h00000000, 32'hC0400000, 2'b01, 32'h40400000, 3, 1'b0, 1'b0);
    op_check("pz_nz", 32'h00000000, 32'h80000000, 2'b00, 32'h00000000, 3, 1'b0, 1'b0);
    op_check("nz_nz", 32'h80000000, 32'h00000000, 2'b01, 32'h80000000, 3, 1'b0, 1'b0);
    op_check("subnorm", 32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 3, 1'b0, 1'b0);
    op_check("inf_fin", 32'h3F800000, 32'hFF800000, 2'b00, 32'hFF800000, 3, 1'b0, 1'b0);
    op_check("nan", 32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 3, 1'b0, 1'b1);
    op_check("rsv_cmd", 32'h3FC00000, 32'h3FC00000, 2'b11, 32'h40400000, 6, 1'b0, 1'b0);

    launch(32'h3F800001, 32'h3F800000, 2'b01);
    wait_done(5, lat, ok);
    chk("long_done", 32'(ok), 32'd1);
    chk("long_lat", 32'(lat), 32'd28);
    chk("long_res", bus_if.result, 32'h34000000);
    chk("long_inv", 32'(bus_if.invalid), 32'd0);

    launch(32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    chk("abort_result", bus_if.result, 32'h0);
    chk("abort_ovf", 32'(bus_if.overflow), 32'd0);
    chk("abort_inv", 32'(bus_if.invalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op_check("post_rst", 32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40400000, 6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
